// File: rtl/pc_control_pkg.sv
// Shared constants and types for the program-counter control slice.
package pc_control_pkg;

    localparam int PC_WIDTH_DEFAULT = 32;

    typedef logic [PC_WIDTH_DEFAULT-1:0] pc_t;

    // Branch condition select encoding carried on in_ctrl_btype.
    localparam logic BTYPE_ZERO = 1'b0;
    localparam logic BTYPE_NEG  = 1'b1;

endpackage

// File: rtl/pc_control_if.sv
// Control/ALU-to-PC bus; counter signals exist only when PCCONTROL_STATS_EN is defined.
interface pc_control_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    // No handshake: every field is sampled each cycle, in_stall is the only hold mechanism.
    logic                in_ctrl_branch;
    logic                in_ctrl_btype;
    logic                in_ctrl_jump;
    logic                in_ctrl_neg;
    logic                in_ctrl_zero;
    logic                in_stall;
    logic [PC_WIDTH-1:0] in_target;
    logic                out;
    logic [PC_WIDTH-1:0] out_pc;
`ifdef PCCONTROL_STATS_EN
    logic [CNT_WIDTH-1:0] out_taken_cnt;
    logic [CNT_WIDTH-1:0] out_branch_cnt;

    modport master (
        output in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_neg, in_ctrl_zero,
        output in_stall, in_target,
        input  out, out_pc, out_taken_cnt, out_branch_cnt
    );

    modport slave (
        input  in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_neg, in_ctrl_zero,
        input  in_stall, in_target,
        output out, out_pc, out_taken_cnt, out_branch_cnt
    );
`else
    modport master (
        output in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_neg, in_ctrl_zero,
        output in_stall, in_target,
        input  out, out_pc
    );

    modport slave (
        input  in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_neg, in_ctrl_zero,
        input  in_stall, in_target,
        output out, out_pc
    );
`endif

endinterface

// File: rtl/pc_branch_resolve.sv
// Combinational take-target resolution from control and ALU flags.
module pc_branch_resolve
    import pc_control_pkg::*;
(
    input  logic ctrl_branch_i,
    input  logic ctrl_btype_i,
    input  logic ctrl_jump_i,
    input  logic ctrl_neg_i,
    input  logic ctrl_zero_i,
    output logic take_o
);

    logic flag_sel;

    // Only the flag named by btype matters; the other one is a don't-care.
    assign flag_sel = (ctrl_btype_i == BTYPE_NEG) ? ctrl_neg_i : ctrl_zero_i;
    assign take_o   = ctrl_jump_i | (ctrl_branch_i & flag_sel);

endmodule

// File: rtl/pc_control.sv
// Architectural PC register with branch/jump select.
// Optional statistics counters are enabled with PCCONTROL_STATS_EN.
module pc_control
    import pc_control_pkg::*;
#(
    parameter int                  PC_WIDTH  = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_control_if.slave bus
);

    logic                take;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    pc_branch_resolve u_resolve (
        .ctrl_branch_i (bus.in_ctrl_branch),
        .ctrl_btype_i  (bus.in_ctrl_btype),
        .ctrl_jump_i   (bus.in_ctrl_jump),
        .ctrl_neg_i    (bus.in_ctrl_neg),
        .ctrl_zero_i   (bus.in_ctrl_zero),
        .take_o        (take)
    );

    assign bus.out    = take;
    assign bus.out_pc = pc_q;

    // Sequential fetch wraps modulo 2^PC_WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (!bus.in_stall) begin
            if (take) begin
                pc_d = bus.in_target;
            end else begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PCCONTROL_STATS_EN
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] branch_cnt_d;
    logic [CNT_WIDTH-1:0] taken_cnt_q;
    logic [CNT_WIDTH-1:0] taken_cnt_d;

    // Taken counts every unstalled take, jumps included; both saturate.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (!bus.in_stall) begin
            if (bus.in_ctrl_branch && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            end
            if (take && (taken_cnt_q != '1)) begin
                taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.out_branch_cnt = branch_cnt_q;
    assign bus.out_taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Directed and random bench for pc_control with a queue-based PC scoreboard.
module tb_pc_control;
    import pc_control_pkg::*;

    localparam int  PCW      = 32;
    localparam int  CW       = 16;
    localparam pc_t RESET_PC = 32'h0;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [PCW-1:0] exp_q[$];
    pc_t            model_pc;
    logic [CW-1:0]  model_bc;
    logic [CW-1:0]  model_tc;

    pc_control_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

    pc_control #(
        .PC_WIDTH  (PCW),
        .RESET_PC  (RESET_PC),
        .CNT_WIDTH (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check out combinationally, push the expected PC, then pop and compare after the edge.
    task automatic step(input logic r, input logic br, input logic bt, input logic jp,
                        input logic ng, input logic zr, input logic st,
                        input logic [PCW-1:0] tgt, input string tag);
        logic exp_out;
        rst                = r;
        bus.in_ctrl_branch = br;
        bus.in_ctrl_btype  = bt;
        bus.in_ctrl_jump   = jp;
        bus.in_ctrl_neg    = ng;
        bus.in_ctrl_zero   = zr;
        bus.in_stall       = st;
        bus.in_target      = tgt;
        #1;
        exp_out = jp | (br & (bt ? ng : zr));
        chk({tag, ".out"}, {63'd0, bus.out}, {63'd0, exp_out});
        if (r) begin
            model_pc = RESET_PC;
            model_bc = '0;
            model_tc = '0;
        end else if (!st) begin
            model_pc = exp_out ? tgt : model_pc + 32'd1;
            if (br && model_bc != '1) model_bc = model_bc + 1'b1;
            if (exp_out && model_tc != '1) model_tc = model_tc + 1'b1;
        end
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, {32'd0, bus.out_pc}, {32'd0, exp_q.pop_front()});
`ifdef PCCONTROL_STATS_EN
        chk({tag, ".bcnt"}, {48'd0, bus.out_branch_cnt}, {48'd0, model_bc});
        chk({tag, ".tcnt"}, {48'd0, bus.out_taken_cnt}, {48'd0, model_tc});
`endif
    endtask

    initial begin
        model_pc = RESET_PC;
        model_bc = '0;
        model_tc = '0;
        rst                = 1'b1;
        bus.in_ctrl_branch = 1'b0;
        bus.in_ctrl_btype  = 1'b0;
        bus.in_ctrl_jump   = 1'b0;
        bus.in_ctrl_neg    = 1'b0;
        bus.in_ctrl_zero   = 1'b0;
        bus.in_stall       = 1'b0;
        bus.in_target      = '0;
        @(posedge clk);
        #1;
        chk("reset.pc", {32'd0, bus.out_pc}, {32'd0, RESET_PC});
`ifdef PCCONTROL_STATS_EN
        chk("reset.bcnt", {48'd0, bus.out_branch_cnt}, 64'd0);
        chk("reset.tcnt", {48'd0, bus.out_taken_cnt}, 64'd0);
`endif

        //   r  br bt jp ng zr st target
        step(0, 0, 0, 0, 0, 0, 0, 32'h0,        "idle");
        step(0, 1, 0, 0, 0, 0, 0, 32'h40,       "bz_nt");
        step(0, 1, 0, 0, 0, 1, 0, 32'h40,       "bz_t");
        step(0, 1, 1, 0, 0, 1, 0, 32'h80,       "bn_nt");
        step(0, 1, 1, 0, 1, 0, 0, 32'h80,       "bn_t");
        step(0, 1, 0, 0, 1, 0, 0, 32'h90,       "bz_negdc");
        step(0, 0, 0, 0, 1, 1, 0, 32'hA0,       "flags_nobr");
        step(0, 0, 0, 1, 0, 0, 0, 32'h1234,     "jump");
        step(0, 0, 0, 1, 0, 0, 1, 32'h999,      "stall_jump");
        step(0, 1, 0, 0, 0, 1, 1, 32'h777,      "stall_br");
        step(0, 0, 0, 0, 0, 0, 1, 32'h0,        "stall_idle");
        step(0, 1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, "jump_ovr");
        step(0, 0, 0, 0, 0, 0, 0, 32'h5,        "wrap");
        step(0, 0, 0, 1, 0, 0, 0, 32'h300,      "jump2");
        step(1, 0, 0, 1, 0, 0, 0, 32'h55,       "rst_jump");
        step(1, 1, 0, 0, 0, 1, 1, 32'h66,       "rst_stall");
        step(0, 0, 0, 0, 0, 0, 0, 32'h0,        "post_rst");

        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), $urandom(), "rand");
        end

`ifdef PCCONTROL_STATS_EN
        step(1, 0, 0, 0, 0, 0, 0, 32'h0,  "st_rst");
        step(0, 1, 0, 0, 0, 1, 0, 32'h10, "st_b1t");
        step(0, 1, 1, 0, 0, 0, 0, 32'h20, "st_b2n");
        step(0, 1, 1, 0, 1, 0, 0, 32'h30, "st_b3t");
        step(0, 0, 0, 1, 0, 0, 0, 32'h40, "st_jmp");
        chk("stats.bcnt3", {48'd0, bus.out_branch_cnt}, 64'd3);
        chk("stats.tcnt3", {48'd0, bus.out_taken_cnt}, 64'd3);
        step(1, 1, 0, 1, 0, 1, 0, 32'h50, "st_clr");
        chk("stats.bcnt0", {48'd0, bus.out_branch_cnt}, 64'd0);
        chk("stats.tcnt0", {48'd0, bus.out_taken_cnt}, 64'd0);
`endif

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter control unit for the single-cycle datapath. It resolves the control unit's branch/jump flags and the ALU's negative/zero flags into one combinational "take target" select, `out`. It also owns the architectural PC register, which it advances each cycle to either PC+1 or the supplied target. It sits between the control/ALU stages and instruction fetch.

## Interface
Parameters:
- `PC_WIDTH`, 32: width of PC and target.
- `RESET_PC`, 0: PC value loaded on reset.
- `CNT_WIDTH`, 16: width of the statistics counters (used only with the stats feature).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_ctrl_branch`  in  1  current instruction is a conditional branch.
- `in_ctrl_btype`  in  1  branch condition select: 0 = branch-if-zero, 1 = branch-if-negative.
- `in_ctrl_jump`  in  1  unconditional jump.
- `in_ctrl_neg`  in  1  ALU negative flag.
- `in_ctrl_zero`  in  1  ALU zero flag.
- `in_stall`  in  1  hold the PC this cycle.
- `in_target`  in  PC_WIDTH  branch/jump target address.
- `out`  out  1  combinational take-target select.
- `out_pc`  out  PC_WIDTH  registered current PC.
- `out_taken_cnt`, `out_branch_cnt`  out  CNT_WIDTH  statistics counters (present only with `PCCONTROL_STATS_EN`).

## Operation
- `out = in_ctrl_jump | (in_ctrl_branch & (in_ctrl_btype ? in_ctrl_neg : in_ctrl_zero))`.
- `out` is purely combinational:
  - It does not depend on `clk` or `rst`.
  - It is valid within the same evaluation as its inputs.
- Jump overrides branch; flags are ignored when branch = 0 and jump = 0.
- The unused flag is a don't-care: btype = 0 ignores neg; btype = 1 ignores zero.
- Next PC:
  - `rst`: `RESET_PC`.
  - else if `in_stall`: hold.
  - else if `out`: `in_target`.
  - else: `out_pc + 1` (word-addressed, modulo 2^PC_WIDTH; all-ones wraps to 0).
- Reset has priority over stall and over a taken branch in the same cycle.

## Timing
- `out`: zero-cycle latency (combinational).
- `out_pc`: updates one cycle after the inputs sampled at the rising edge. There is no multi-cycle state machine.
- Reset values:
  - `out_pc = RESET_PC`.
  - Counters = 0.
  - `out` follows its inputs even during reset.
- Reset asserted mid-stream: the PC reloads on that edge and the pending target is discarded.

## Configuration
- Macro `PCCONTROL_STATS_EN`.
- Defined:
  - `out_branch_cnt` increments on each unstalled, non-reset cycle with `in_ctrl_branch = 1`.
  - `out_taken_cnt` increments on each such cycle with `out = 1`. This includes jumps.
  - Both counters saturate at all-ones and clear on `rst`.
- Undefined: counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package `pc_control_pkg`:
  - `PC_WIDTH` default constant.
  - `pc_t` typedef.
  - btype encoding constants `BTYPE_ZERO = 0`, `BTYPE_NEG = 1`.
- One natural sub-module, `pc_branch_resolve`: the combinational take logic producing `out`. It is instantiated by `pc_control`. The PC register and counters stay in the top level.

## Test plan
- All control inputs 0, neg = zero = 0 → `out = 0`; after one edge, PC 0 → 1.
- branch = 1, btype = 0, zero = 0 → `out = 0`. Then set zero = 1 → `out = 1`; with `in_target = 0x40`, `out_pc = 0x40` next cycle.
- branch = 1, btype = 1, zero = 1, neg = 0 → `out = 0`. Then neg = 1 → `out = 1`.
- jump = 1, branch = 0, flags 0 → `out = 1`; PC loads `in_target = 0x1234`. Asserting `in_stall` holds PC at 0x1234.
- Boundary cases:
  - PC = 0xFFFFFFFF, not taken → PC = 0.
  - `rst` with jump = 1 → PC = `RESET_PC`, while `out` still reads 1.
- With `PCCONTROL_STATS_EN`: 3 branches (2 taken) plus 1 jump → `out_branch_cnt = 3`, `out_taken_cnt = 3`. `rst` clears both to 0.
